// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and parity-mode constants for the UART TX arbiter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter 0..CLK_DIV-1, restarted by the frame start strobe
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [$clog2(CLK_DIV)-1:0] count,
    output logic                       bit_end
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    always_ff @(posedge clk) begin
        if (rst || start || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter that frames one requester byte at a time onto a UART TX line
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          frame_done
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SUM_W = ID_W + 1;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(CLK_DIV - 2);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic ODD_SEL = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    uart_tx_state_e         state;
    logic [ID_W-1:0]        rr_ptr;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   par_q;
    logic [IDX_W-1:0]       bit_idx;
    logic [CNT_W-1:0]       baud_cnt;
    logic                   bit_end;
    logic                   last_stop;
    logic                   window;
    logic                   found;
    logic                   accept;
    logic [ID_W-1:0]        winner;
    logic [DATA_WIDTH-1:0]  win_data;

    assign last_stop = (state == STOP) && (bit_idx == LAST_STOP);
    // Reset is folded into the window so no handshake is offered while rst is high.
    assign window    = !rst && ((state == IDLE) || (last_stop && bit_end));
    assign accept    = window && found;
    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        logic [SUM_W-1:0] cand;
        cand   = '0;
        found  = 1'b0;
        winner = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .count   (baud_cnt),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= '0;
            frame_done <= 1'b0;
            rr_ptr     <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            bit_idx    <= '0;
        end else begin
            // Registered pulse: armed one cycle early so it lands on the final stop cycle.
            frame_done <= last_stop && (baud_cnt == PRE_END);
            if (accept) begin
                state    <= START;
                tx       <= 1'b0;
                busy     <= 1'b1;
                grant_id <= winner;
                rr_ptr   <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                shreg    <= win_data;
                par_q    <= (^win_data) ^ ODD_SEL;
                bit_idx  <= '0;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                    DATA: begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par_q;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        bit_idx <= '0;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (default and odd-parity/2-stop instances)
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic             tx, busy, frame_done;
    logic [1:0]       grant_id;

    logic [NR-1:0]    b_valid = '0;
    logic [NR*DW-1:0] b_data  = '0;
    logic [NR-1:0]    b_ready;
    logic             b_tx, b_busy, b_done;
    logic [1:0]       b_gid;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .CLK_DIV(CD),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
        .frame_done(frame_done)
    );

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .CLK_DIV(CD),
        .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_odd (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .tx(b_tx), .busy(b_busy), .grant_id(b_gid),
        .frame_done(b_done)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         ack_cnt[NR];
    logic       auto_drop = 1'b1;
    logic [NR-1:0] hs_pend = '0;
    logic [NR-1:0] b_pend  = '0;

    // Requester model: drops valid the cycle after its handshake and counts acks.
    always begin
        @(negedge clk);
        if (auto_drop) req_valid = req_valid & ~hs_pend;
        b_valid = b_valid & ~b_pend;
        #1;
        hs_pend = req_valid & req_ready;
        b_pend  = b_valid & b_ready;
        for (int i = 0; i < NR; i++) if (hs_pend[i]) ack_cnt[i]++;
    end

    task automatic rx_frame(input bit sel_b, input int stop_bits, output int waited,
                            output int gid, output logic [7:0] data, output logic par,
                            output int stop_hi, output int fd_idx, output int fd_cnt,
                            output int bad);
        int   n, bitpos;
        logic t, cur;
        waited = 0; gid = -1; data = '0; par = 1'bx;
        stop_hi = 0; fd_idx = -1; fd_cnt = 0; bad = 0; cur = 1'b0;
        n = CD * (2 + DW + stop_bits);
        do begin
            @(negedge clk);
            waited++;
        end while ((sel_b ? b_tx : tx) !== 1'b0 && waited < 3000);
        if (waited >= 3000) begin
            bad = 1;
            return;
        end
        gid = sel_b ? int'(b_gid) : int'(grant_id);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            t = sel_b ? b_tx : tx;
            if ((sel_b ? b_busy : busy) !== 1'b1) bad++;
            if ((sel_b ? b_done : frame_done) === 1'b1) begin
                fd_cnt++;
                fd_idx = c;
            end
            bitpos = c / CD;
            if (c % CD == 0) cur = t;
            else if (t !== cur) bad++;
            if (bitpos == 0) begin
                if (t !== 1'b0) bad++;
            end else if (bitpos <= DW) data[bitpos-1] = t;
            else if (bitpos == DW + 1) par = t;
            else if (t === 1'b1) stop_hi++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests += 5;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", frame_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int w, g, sh, fi, fc, bd;
        logic [7:0] d;
        logic p;
        exp_t e;
        req_data[7:0] = 8'hA5;
        req_valid[0]  = 1'b1;
        exp_q.push_back('{0, 8'hA5});
        rx_frame(1'b0, 1, w, g, d, p, sh, fi, fc, bd);
        e = exp_q.pop_front();
        tests += 8;
        if (w != 1) begin fails++; $display("FAIL single_latency: got %0d want 1", w); end
        if (g != e.id) begin fails++; $display("FAIL single_gid: got %0d want %0d", g, e.id); end
        if (d !== e.data) begin fails++; $display("FAIL single_data: got %h want %h", d, e.data); end
        if (p !== ^e.data) begin fails++; $display("FAIL single_parity: got %b want %b", p, ^e.data); end
        if (sh != CD) begin fails++; $display("FAIL single_stop: got %0d want %0d", sh, CD); end
        if (fi != CD*11-1) begin fails++; $display("FAIL single_done_pos: got %0d want %0d", fi, CD*11-1); end
        if (fc != 1) begin fails++; $display("FAIL single_done_cnt: got %0d want 1", fc); end
        if (bd != 0) begin fails++; $display("FAIL single_shape: got %0d bad cycles want 0", bd); end
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++; $display("FAIL single_idle_after: got busy=%b tx=%b want 0/1", busy, tx);
        end
    endtask

    task automatic test_all_requesters();
        int w, g, sh, fi, fc, bd;
        logic [7:0] d;
        logic p;
        exp_t e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) exp_q.push_back('{i, 8'h11 * (i + 1)});
        for (int k = 0; k < NR; k++) begin
            rx_frame(1'b0, 1, w, g, d, p, sh, fi, fc, bd);
            e = exp_q.pop_front();
            tests += 5;
            if (w != 1) begin fails++; $display("FAIL b2b_gap%0d: got %0d want 1", k, w); end
            if (g != e.id) begin fails++; $display("FAIL b2b_gid%0d: got %0d want %0d", k, g, e.id); end
            if (d !== e.data) begin fails++; $display("FAIL b2b_data%0d: got %h want %h", k, d, e.data); end
            if (p !== ^e.data) begin fails++; $display("FAIL b2b_par%0d: got %b want %b", k, p, ^e.data); end
            if (fi != CD*11-1 || bd != 0) begin
                fails++; $display("FAIL b2b_frame%0d: got done@%0d bad=%0d want %0d/0", k, fi, bd, CD*11-1);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_held_valid();
        int w, g, sh, fi, fc, bd;
        int a0[NR];
        logic [7:0] d;
        logic p;
        exp_t e;
        for (int i = 0; i < NR; i++) a0[i] = ack_cnt[i];
        auto_drop = 1'b0;
        req_data  = {8'h00, 8'hC3, 8'h00, 8'h3C};
        req_valid = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{0, 8'h3C});
            exp_q.push_back('{2, 8'hC3});
        end
        for (int k = 0; k < 4; k++) begin
            rx_frame(1'b0, 1, w, g, d, p, sh, fi, fc, bd);
            e = exp_q.pop_front();
            tests += 2;
            if (g != e.id || w != 1) begin
                fails++; $display("FAIL held_gid%0d: got %0d gap %0d want %0d gap 1", k, g, w, e.id);
            end
            if (d !== e.data) begin fails++; $display("FAIL held_data%0d: got %h want %h", k, d, e.data); end
        end
        req_valid = '0;
        auto_drop = 1'b1;
        repeat (3) @(negedge clk);
        tests += 2;
        if (ack_cnt[0] - a0[0] != 2 || ack_cnt[2] - a0[2] != 2) begin
            fails++; $display("FAIL held_acks02: got %0d,%0d want 2,2", ack_cnt[0] - a0[0], ack_cnt[2] - a0[2]);
        end
        if (ack_cnt[1] != a0[1] || ack_cnt[3] != a0[3]) begin
            fails++; $display("FAIL held_acks13: got %0d,%0d want 0,0", ack_cnt[1] - a0[1], ack_cnt[3] - a0[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w, g, sh, fi, fc, bd, n, a0;
        logic [7:0] d;
        logic p;
        exp_t e;
        a0 = ack_cnt[0];
        req_data[7:0] = 8'h96;
        req_valid[0]  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 100);
        tests++;
        if (n >= 100) begin fails++; $display("FAIL rstmid_start: got no start want start"); end
        repeat (CD*4 + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests += 4;
        if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (grant_id !== 2'd0) begin fails++; $display("FAIL rstmid_gid: got %0d want 0", grant_id); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", frame_done); end
        rst = 1'b0;
        bd = 0;
        repeat (300) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || tx !== 1'b1) bd++;
        end
        tests += 2;
        if (bd != 0) begin fails++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bd); end
        if (ack_cnt[0] - a0 != 1) begin fails++; $display("FAIL rstmid_reack: got %0d acks want 1", ack_cnt[0] - a0); end
        req_data[15:0] = 16'h8001;
        req_valid = 4'b0011;
        exp_q.push_back('{0, 8'h01});
        exp_q.push_back('{1, 8'h80});
        for (int k = 0; k < 2; k++) begin
            rx_frame(1'b0, 1, w, g, d, p, sh, fi, fc, bd);
            e = exp_q.pop_front();
            tests++;
            if (g != e.id || d !== e.data) begin
                fails++; $display("FAIL rstmid_regrant%0d: got id %0d data %h want id %0d data %h", k, g, d, e.id, e.data);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_odd_two_stop();
        int w, g, sh, fi, fc, bd;
        logic [7:0] d;
        logic p;
        exp_t e;
        b_data[7:0] = 8'h00;
        b_valid[0]  = 1'b1;
        exp_q.push_back('{0, 8'h00});
        rx_frame(1'b1, 2, w, g, d, p, sh, fi, fc, bd);
        e = exp_q.pop_front();
        tests += 6;
        if (g != e.id || d !== e.data) begin
            fails++; $display("FAIL odd_frame: got id %0d data %h want id %0d data %h", g, d, e.id, e.data);
        end
        if (p !== ~^e.data) begin fails++; $display("FAIL odd_parity: got %b want %b", p, ~^e.data); end
        if (sh != 2*CD) begin fails++; $display("FAIL odd_stop: got %0d want %0d", sh, 2*CD); end
        if (fi != CD*12-1) begin fails++; $display("FAIL odd_done_pos: got %0d want %0d", fi, CD*12-1); end
        if (fc != 1 || bd != 0) begin fails++; $display("FAIL odd_shape: got done=%0d bad=%0d want 1/0", fc, bd); end
        if (w != 1) begin fails++; $display("FAIL odd_latency: got %0d want 1", w); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_idle();
        int bd;
        req_valid = '0;
        bd = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0) bd++;
        end
        tests++;
        if (bd != 0) begin fails++; $display("FAIL idle_quiet: got %0d active cycles want 0", bd); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        test_reset();
        test_single_frame();
        test_all_requesters();
        test_held_valid();
        test_reset_mid_frame();
        test_odd_two_stop();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
